// File: rtl/gather_output_arbiter.sv
// gather_output_arbiter
//   Packet-level round-robin arbiter and registered output stage for one
//   gather-router output port. A packet wins the port on its head flit and
//   keeps it until its tail flit, so flits of different packets never mix.
//
// Ports
//   clk      in   1      clock
//   rst      in   1      synchronous active-high reset
//   valid_i  in   NP     per-input flit valid (already routed here)
//   data_i   in   NP*DW  per-input flit, input i at [i*DW +: DW]
//   ready_o  out  NP     per-input accept (combinational, at most one set)
//   valid_o  out  1      output flit valid (registered)
//   data_o   out  DW     output flit (registered)
//   ready_i  in   1      downstream accept
//   owner_o  out  NP     one-hot packet owner while locked, 0 when idle
//   err_o    out  1      sticky protocol-error flag
module gather_output_arbiter #(
  parameter int unsigned NP        = 5,
  parameter int unsigned DW        = 16,
  parameter logic [1:0]  FT_HEAD   = 2'b00,
  parameter logic [1:0]  FT_BODY   = 2'b01,
  parameter logic [1:0]  FT_TAIL   = 2'b10,
  parameter logic [1:0]  FT_SINGLE = 2'b11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NP-1:0]    valid_i,
  input  logic [NP*DW-1:0] data_i,
  output logic [NP-1:0]    ready_o,
  output logic             valid_o,
  output logic [DW-1:0]    data_o,
  input  logic             ready_i,
  output logic [NP-1:0]    owner_o,
  output logic             err_o
);

  localparam int unsigned PW   = (NP > 1) ? $clog2(NP) : 1;
  localparam logic [PW-1:0] LAST = PW'(NP - 1);

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [PW-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [PW-1:0]   r_owner_idx, w_owner_idx_nxt;
  logic [NP-1:0]   r_owner, w_owner_nxt;
  logic            r_valid, w_valid_nxt;
  logic [DW-1:0]   r_data, w_data_nxt;
  logic            r_err, w_err_nxt;

  logic [DW-1:0]   w_flit  [NP];
  logic [1:0]      w_ftype [NP];
  logic [NP-1:0]   w_elig;
  logic            w_found;
  logic [PW-1:0]   w_winner;
  logic            w_space;
  logic [NP-1:0]   w_ready;
  logic            w_fire;
  logic [PW-1:0]   w_sel_idx;
  logic [DW-1:0]   w_sel_data;
  logic [1:0]      w_sel_type;

  // Pointer increment with explicit wrap, NP need not be a power of two.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  // Unpack per-input flits; only HEAD or SINGLE may open a new packet.
  for (genvar g = 0; g < NP; g++) begin : g_in
    assign w_flit[g]  = data_i[g*DW +: DW];
    assign w_ftype[g] = data_i[g*DW + DW - 2 +: 2];
    assign w_elig[g]  = valid_i[g] & ((w_ftype[g] == FT_HEAD) | (w_ftype[g] == FT_SINGLE));
  end

  // Round-robin search: first eligible input at or after the pointer.
  always_comb begin : p_search
    int unsigned idx;
    w_found  = 1'b0;
    w_winner = '0;
    idx      = 0;
    for (int unsigned k = 0; k < NP; k++) begin
      idx = 32'(r_rr_ptr) + k;
      if (idx >= NP) idx = idx - NP;
      if (!w_found && w_elig[PW'(idx)]) begin
        w_found  = 1'b1;
        w_winner = PW'(idx);
      end
    end
  end

  // Output register can take a flit if empty or draining this cycle.
  assign w_space = ~r_valid | ready_i;

  // Grant: idle winner or current owner, gated by space; forced off in reset.
  always_comb begin : p_ready
    w_ready = '0;
    if (!rst) begin
      case (r_state)
        ST_IDLE:   if (w_found) w_ready[w_winner] = w_space;
        ST_LOCKED: w_ready = r_owner & {NP{w_space}};
        default:   w_ready = '0;
      endcase
    end
  end

  assign w_fire     = |(valid_i & w_ready);
  assign w_sel_idx  = (r_state == ST_IDLE) ? w_winner : r_owner_idx;
  assign w_sel_data = w_flit[w_sel_idx];
  assign w_sel_type = w_ftype[w_sel_idx];

  // Next-state and output-register logic.
  always_comb begin : p_next
    w_state_nxt     = r_state;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_owner_nxt     = r_owner;
    w_owner_idx_nxt = r_owner_idx;
    w_valid_nxt     = r_valid;
    w_data_nxt      = r_data;
    w_err_nxt       = r_err;

    if (w_fire) begin
      w_valid_nxt = 1'b1;
      w_data_nxt  = w_sel_data;
    end else if (ready_i) begin
      w_valid_nxt = 1'b0;
    end

    case (r_state)
      ST_IDLE: begin
        if (w_fire) begin
          if (w_sel_type == FT_HEAD) begin
            w_state_nxt               = ST_LOCKED;
            w_owner_nxt               = '0;
            w_owner_nxt[w_winner]     = 1'b1;
            w_owner_idx_nxt           = w_winner;
          end else if (w_sel_type == FT_SINGLE) begin
            w_rr_ptr_nxt = wrap_inc(w_winner);
          end
        end
        // Valid traffic that cannot start a packet is a protocol error.
        if ((|valid_i) && !w_found) w_err_nxt = 1'b1;
      end
      ST_LOCKED: begin
        if (w_fire) begin
          case (w_sel_type)
            FT_BODY: w_state_nxt = ST_LOCKED;
            FT_TAIL: begin
              w_state_nxt     = ST_IDLE;
              w_owner_nxt     = '0;
              w_owner_idx_nxt = '0;
              w_rr_ptr_nxt    = wrap_inc(r_owner_idx);
            end
            // Nested HEAD/SINGLE: forwarded, lock kept, error flagged.
            default: w_err_nxt = 1'b1;
          endcase
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_owner_idx <= '0;
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_owner     <= w_owner_nxt;
      r_owner_idx <= w_owner_idx_nxt;
      r_valid     <= w_valid_nxt;
      r_data      <= w_data_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign ready_o = w_ready;
  assign valid_o = r_valid;
  assign data_o  = r_data;
  assign owner_o = r_owner;
  assign err_o   = r_err;

endmodule

// File: tb/tb_gather_output_arbiter.sv
// tb_gather_output_arbiter
//   Directed scenarios plus randomized packet traffic for
//   gather_output_arbiter, checked against a packet-level reference model.
module tb_gather_output_arbiter;

  localparam int NP = 5;
  localparam int DW = 16;
  localparam logic [1:0] FT_HEAD   = 2'b00;
  localparam logic [1:0] FT_BODY   = 2'b01;
  localparam logic [1:0] FT_TAIL   = 2'b10;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NP-1:0]    valid_i = '0;
  logic [NP*DW-1:0] data_i = '0;
  logic [NP-1:0]    ready_o;
  logic             valid_o;
  logic [DW-1:0]    data_o;
  logic             ready_i = 1'b1;
  logic [NP-1:0]    owner_o;
  logic             err_o;

  int checks = 0;
  int failures = 0;

  // Reference model state: packet lock, owner, round-robin pointer, output slot.
  bit            m_lock = 0;
  int            m_own  = 0;
  int            m_rr   = 0;
  bit            m_err  = 0;
  bit            m_vo   = 0;
  logic [DW-1:0] m_do   = '0;

  // Per-input flit sources.
  logic [DW-1:0] srcq [NP][$];

  always #5 clk = ~clk;

  gather_output_arbiter #(.NP(NP), .DW(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .valid_i (valid_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .data_o  (data_o),
    .ready_i (ready_i),
    .owner_o (owner_o),
    .err_o   (err_o)
  );

  function automatic logic [DW-1:0] mk(input logic [1:0] t, input int p);
    return {t, (DW-2)'(p)};
  endfunction

  function automatic logic [1:0] ftype(input logic [DW-1:0] f);
    return f[DW-1:DW-2];
  endfunction

  function automatic logic [DW-1:0] din(input int i);
    return data_i[i*DW +: DW];
  endfunction

  task automatic set_flit(input int i, input logic [DW-1:0] f);
    data_i[i*DW +: DW] = f;
  endtask

  function automatic logic [NP-1:0] model_owner();
    logic [NP-1:0] o;
    o = '0;
    if (m_lock) o[m_own] = 1'b1;
    return o;
  endfunction

  // Which input the port should accept given the current inputs.
  function automatic logic [NP-1:0] model_ready();
    logic [NP-1:0] r;
    bit space;
    int i;
    logic [1:0] t;
    r = '0;
    space = !m_vo || ready_i;
    if (rst) return r;
    if (m_lock) begin
      r[m_own] = space;
      return r;
    end
    for (int k = 0; k < NP; k++) begin
      i = (m_rr + k) % NP;
      t = ftype(din(i));
      if (valid_i[i] && (t == FT_HEAD || t == FT_SINGLE)) begin
        r[i] = space;
        return r;
      end
    end
    return r;
  endfunction

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic tick();
    logic [NP-1:0] r;
    int fi;
    bit elig;
    logic [1:0] t;
    bit n_lock, n_vo, n_err;
    int n_own, n_rr;
    logic [DW-1:0] n_do;
    r = model_ready();
    fi = -1;
    elig = 0;
    for (int i = 0; i < NP; i++) begin
      if (valid_i[i] && r[i]) fi = i;
      t = ftype(din(i));
      if (valid_i[i] && (t == FT_HEAD || t == FT_SINGLE)) elig = 1;
    end
    n_lock = m_lock; n_own = m_own; n_rr = m_rr;
    n_err = m_err; n_vo = m_vo; n_do = m_do;
    if (rst) begin
      n_lock = 0; n_own = 0; n_rr = 0; n_err = 0; n_vo = 0; n_do = '0;
    end else begin
      if (fi >= 0) begin
        t = ftype(din(fi));
        n_vo = 1;
        n_do = din(fi);
        if (!m_lock) begin
          if (t == FT_HEAD) begin n_lock = 1; n_own = fi; end
          else n_rr = (fi + 1) % NP;
        end else if (t == FT_TAIL) begin
          n_lock = 0;
          n_rr = (m_own + 1) % NP;
        end else if (t != FT_BODY) begin
          n_err = 1;
        end
      end else if (ready_i) begin
        n_vo = 0;
      end
      if (!m_lock && (|valid_i) && !elig) n_err = 1;
    end
    @(posedge clk);
    m_lock = n_lock; m_own = n_own; m_rr = n_rr;
    m_err = n_err; m_vo = n_vo; m_do = n_do;
    if (fi >= 0 && srcq[fi].size() > 0) void'(srcq[fi].pop_front());
    #1;
  endtask

  task automatic drive_fronts(input logic [NP-1:0] mask);
    for (int i = 0; i < NP; i++) begin
      if (mask[i] && srcq[i].size() > 0) begin
        valid_i[i] = 1'b1;
        set_flit(i, srcq[i][0]);
      end else begin
        valid_i[i] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < NP; i++) srcq[i].delete();
    rst = 1'b1;
    valid_i = '0;
    data_i = '0;
    ready_i = 1'b1;
    #1;
    tick();
    rst = 1'b0;
  endtask

  task automatic push_pkt(input int i, input int len, input int base);
    if (len == 1) srcq[i].push_back(mk(FT_SINGLE, base));
    else begin
      srcq[i].push_back(mk(FT_HEAD, base));
      for (int b = 1; b < len - 1; b++) srcq[i].push_back(mk(FT_BODY, base + b));
      srcq[i].push_back(mk(FT_TAIL, base + len - 1));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ready_i = 1'b1;
    valid_i = '1;
    for (int i = 0; i < NP; i++) set_flit(i, mk(FT_HEAD, i));
    #1;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (ready_o !== '0) begin
        failures++; $display("FAIL reset_ready got=%b exp=%b", ready_o, 5'b0);
      end
      tick();
      checks++;
      if (valid_o !== 1'b0 || err_o !== 1'b0 || owner_o !== '0) begin
        failures++;
        $display("FAIL reset_outputs got valid=%b err=%b owner=%b exp 0/0/00000", valid_o, err_o, owner_o);
      end
    end
    rst = 1'b0;
    valid_i = '0;
  endtask

  task automatic test_single();
    valid_i = 5'b00100;
    set_flit(2, 16'hC005);
    ready_i = 1'b1;
    #1;
    checks++;
    if (ready_o !== 5'b00100 || ready_o !== model_ready()) begin
      failures++; $display("FAIL single_ready got=%b exp=%b", ready_o, 5'b00100);
    end
    tick();
    checks++;
    if (valid_o !== 1'b1 || data_o !== 16'hC005) begin
      failures++; $display("FAIL single_out got=%b/%h exp=1/c005", valid_o, data_o);
    end
    // Pointer now 3: of inputs 1 and 4, input 4 must win.
    valid_i = 5'b10010;
    set_flit(1, 16'hC011);
    set_flit(4, 16'hC044);
    #1;
    checks++;
    if (ready_o !== 5'b10000) begin
      failures++; $display("FAIL single_rr_next got=%b exp=%b", ready_o, 5'b10000);
    end
    tick();
    checks++;
    if (data_o !== 16'hC044 || data_o !== m_do) begin
      failures++; $display("FAIL single_second got=%h exp=c044", data_o);
    end
    valid_i = '0;
    #1;
    tick();
    checks++;
    if (valid_o !== 1'b0) begin
      failures++; $display("FAIL single_drain got=%b exp=0", valid_o);
    end
  endtask

  task automatic test_contention();
    logic [DW-1:0] got[$];
    logic [DW-1:0] exp[$];
    int first, last;
    do_reset();
    push_pkt(0, 3, 'h010);
    push_pkt(3, 3, 'h030);
    exp = srcq[0];
    for (int k = 0; k < 3; k++) exp.push_back(srcq[3][k]);
    first = -1; last = -1;
    for (int c = 0; c < 12; c++) begin
      drive_fronts('1);
      #1;
      if (valid_o) begin
        got.push_back(data_o);
        if (first < 0) first = c;
        last = c;
      end
      checks++;
      if (ready_o !== model_ready()) begin
        failures++; $display("FAIL cont_ready c=%0d got=%b exp=%b", c, ready_o, model_ready());
      end
      if (got.size() < 3) begin
        checks++;
        if (ready_o[3] !== 1'b0) begin
          failures++; $display("FAIL cont_block3 c=%0d got=%b exp=0", c, ready_o[3]);
        end
      end
      if (c == 1 || c == 2) begin
        checks++;
        if (owner_o !== 5'b00001) begin
          failures++; $display("FAIL cont_owner c=%0d got=%b exp=00001", c, owner_o);
        end
      end
      tick();
    end
    checks++;
    if (got.size() != 6 || got != exp) begin
      failures++; $display("FAIL cont_order got=%p exp=%p", got, exp);
    end
    checks++;
    if (last - first != 5) begin
      failures++; $display("FAIL cont_b2b got span=%0d exp=5", last - first);
    end
  endtask

  task automatic test_stall();
    logic [NP-1:0] mask, r;
    bit tail0, tail_now;
    do_reset();
    push_pkt(0, 4, 'h100);
    push_pkt(4, 2, 'h140);
    tail0 = 0;
    for (int c = 0; c < 16; c++) begin
      mask = '1;
      if (c >= 2 && c < 5) mask[0] = 1'b0;
      drive_fronts(mask);
      #1;
      r = model_ready();
      checks++;
      if (ready_o !== r || owner_o !== model_owner()) begin
        failures++; $display("FAIL stall_ready c=%0d got=%b/%b exp=%b/%b", c, ready_o, owner_o, r, model_owner());
      end
      if (!tail0) begin
        checks++;
        if (ready_o[4] !== 1'b0) begin
          failures++; $display("FAIL stall_block4 c=%0d got=%b exp=0", c, ready_o[4]);
        end
      end
      tail_now = valid_i[0] && r[0] && ftype(din(0)) == FT_TAIL;
      tick();
      if (tail_now) tail0 = 1;
    end
    checks++;
    if (srcq[0].size() != 0 || srcq[4].size() != 0) begin
      failures++; $display("FAIL stall_timeout got left=%0d/%0d exp=0/0", srcq[0].size(), srcq[4].size());
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp[$];
    logic [DW-1:0] got[$];
    logic [DW-1:0] held;
    int when[$];
    do_reset();
    push_pkt(1, 5, 'h200);
    exp = srcq[1];
    held = '0;
    for (int c = 0; c < 12; c++) begin
      ready_i = !(c >= 2 && c < 6);
      drive_fronts('1);
      #1;
      if (c == 2) held = data_o;
      if (c >= 2 && c < 6) begin
        checks++;
        if (valid_o !== 1'b1 || data_o !== held || ready_o !== '0) begin
          failures++; $display("FAIL bp_hold c=%0d got=%b/%h/%b exp=1/%h/00000", c, valid_o, data_o, ready_o, held);
        end
      end
      checks++;
      if (ready_o !== model_ready() || data_o !== m_do) begin
        failures++; $display("FAIL bp_model c=%0d got=%b/%h exp=%b/%h", c, ready_o, data_o, model_ready(), m_do);
      end
      if (valid_o && ready_i) begin
        got.push_back(data_o);
        when.push_back(c);
      end
      tick();
    end
    ready_i = 1'b1;
    checks++;
    if (got != exp) begin
      failures++; $display("FAIL bp_stream got=%p exp=%p", got, exp);
    end
    checks++;
    if (when.size() != 5 || when[4] - when[1] != 3) begin
      failures++; $display("FAIL bp_rate got=%p exp=consecutive after release", when);
    end
  endtask

  task automatic test_error_reset();
    do_reset();
    valid_i = 5'b00010;
    set_flit(1, mk(FT_BODY, 'h111));
    #1;
    checks++;
    if (ready_o !== '0) begin
      failures++; $display("FAIL err_nogrant got=%b exp=00000", ready_o);
    end
    tick();
    checks++;
    if (err_o !== 1'b1) begin
      failures++; $display("FAIL err_set got=%b exp=1", err_o);
    end
    valid_i = '0;
    #1;
    tick();
    tick();
    checks++;
    if (err_o !== 1'b1) begin
      failures++; $display("FAIL err_sticky got=%b exp=1", err_o);
    end
    valid_i = 5'b00100;
    set_flit(2, mk(FT_SINGLE, 'h222));
    #1;
    tick();
    valid_i = 5'b01000;
    set_flit(3, mk(FT_HEAD, 'h333));
    #1;
    tick();
    set_flit(3, mk(FT_BODY, 'h334));
    #1;
    tick();
    checks++;
    if (owner_o !== 5'b01000 || valid_o !== 1'b1) begin
      failures++; $display("FAIL err_midpkt got=%b/%b exp=01000/1", owner_o, valid_o);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (ready_o !== '0) begin
      failures++; $display("FAIL rst_ready got=%b exp=00000", ready_o);
    end
    tick();
    rst = 1'b0;
    checks++;
    if (valid_o !== 1'b0 || err_o !== 1'b0 || owner_o !== '0) begin
      failures++; $display("FAIL rst_clear got=%b/%b/%b exp=0/0/00000", valid_o, err_o, owner_o);
    end
    valid_i = 5'b10001;
    set_flit(0, mk(FT_HEAD, 'h001));
    set_flit(4, mk(FT_HEAD, 'h004));
    #1;
    checks++;
    if (ready_o !== 5'b00001 || ready_o !== model_ready()) begin
      failures++; $display("FAIL rst_rr_zero got=%b exp=00001", ready_o);
    end
    tick();
  endtask

  task automatic test_random();
    logic [NP-1:0] mask;
    int base;
    do_reset();
    base = 'h400;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NP; i++) begin
        if (srcq[i].size() == 0 && $urandom_range(0, 3) == 0) begin
          push_pkt(i, $urandom_range(1, 4), base);
          base += 8;
        end
        mask[i] = ($urandom_range(0, 9) < 8);
      end
      ready_i = ($urandom_range(0, 3) != 0);
      drive_fronts(mask);
      #1;
      checks++;
      if (ready_o !== model_ready() || valid_o !== m_vo || data_o !== m_do ||
          owner_o !== model_owner() || err_o !== m_err) begin
        failures++;
        $display("FAIL rand c=%0d got rdy=%b v=%b d=%h own=%b err=%b exp rdy=%b v=%b d=%h own=%b err=%b",
                 c, ready_o, valid_o, data_o, owner_o, err_o,
                 model_ready(), m_vo, m_do, model_owner(), m_err);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_stall();
    test_backpressure();
    test_error_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
